// File: rtl/uart_frame_if.sv
// uart_frame_if: serial line, 16x-baud enable and framed-payload outputs of the PC->FPGA receive path
interface uart_frame_if #(parameter int PAYLOAD_BYTES = 20);
  logic clken_16bps;
  logic fpga_rxd;
  logic [8*PAYLOAD_BYTES-1:0] output_data;
  logic frame_valid;
  logic frame_err;
  logic rxd_busy;
  modport master(output clken_16bps, fpga_rxd, input output_data, frame_valid, frame_err, rxd_busy);
  modport slave(input clken_16bps, fpga_rxd, output output_data, frame_valid, frame_err, rxd_busy);
endinterface

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 8N1 receiver that locks on a doubled header byte and emits PAYLOAD_BYTES-byte frames.
// Define UART_FRAME_TIMEOUT_EN to abort a payload after TIMEOUT_TICKS idle clken ticks.
module uart_frame_rx #(
  parameter int PAYLOAD_BYTES = 20,
`ifdef UART_FRAME_TIMEOUT_EN
  parameter int TIMEOUT_TICKS = 640,
`endif
  parameter logic [7:0] HDR_BYTE = 8'h5A
) (
  input logic clk_50m,
  input logic rst_n,
  uart_frame_if.slave u
);
  localparam int W = 8 * PAYLOAD_BYTES;
  localparam int CW = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(PAYLOAD_BYTES - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_st_t;
  typedef enum logic [1:0] {HUNT0, HUNT1, PAYLOAD} frm_st_t;
  bit_st_t bst, bst_n;
  frm_st_t fst, fst_n;
  logic [1:0] rxd_sync;
  logic rxd;
  logic [3:0] tcnt, tcnt_n;
  logic [2:0] bcnt, bcnt_n;
  logic [7:0] rx_byte, rx_byte_n;
  logic byte_stb, byte_stb_n, byte_ferr, byte_ferr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0] shreg, shreg_n, data_n;
  logic valid_n, err_n, busy_n, tmo_hit;
  assign rxd = rxd_sync[1];
  // Bit FSM: start resampled 8 ticks after the falling edge, then every 16 ticks
  always_comb begin
    bst_n = bst;
    tcnt_n = tcnt;
    bcnt_n = bcnt;
    rx_byte_n = rx_byte;
    byte_stb_n = 1'b0;
    byte_ferr_n = 1'b0;
    if (u.clken_16bps) begin
      tcnt_n = tcnt + 4'd1;
      case (bst)
        IDLE: begin
          tcnt_n = '0;
          bcnt_n = '0;
          bst_n = rxd ? IDLE : START;
        end
        START: if (tcnt == 4'd7) begin
          tcnt_n = '0;
          bst_n = rxd ? IDLE : DATA;
        end
        DATA: if (tcnt == 4'd15) begin
          rx_byte_n = {rxd, rx_byte[7:1]};
          bcnt_n = bcnt + 3'd1;
          bst_n = (bcnt == 3'd7) ? STOP : DATA;
        end
        STOP: if (tcnt == 4'd15) begin
          bst_n = IDLE;
          byte_stb_n = rxd;
          byte_ferr_n = !rxd;
        end
        default: bst_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) begin
      rxd_sync <= 2'b11;
      bst <= IDLE;
      tcnt <= '0;
      bcnt <= '0;
      rx_byte <= '0;
      byte_stb <= 1'b0;
      byte_ferr <= 1'b0;
    end else begin
      rxd_sync <= {rxd_sync[0], u.fpga_rxd};
      bst <= bst_n;
      tcnt <= tcnt_n;
      bcnt <= bcnt_n;
      rx_byte <= rx_byte_n;
      byte_stb <= byte_stb_n;
      byte_ferr <= byte_ferr_n;
    end
`ifdef UART_FRAME_TIMEOUT_EN
  localparam logic [9:0] TMO = 10'(TIMEOUT_TICKS);
  logic [9:0] tmo;
  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) tmo <= '0;
    else if (fst != PAYLOAD || byte_stb || byte_ferr) tmo <= '0;
    else if (u.clken_16bps) tmo <= tmo + 10'd1;
  assign tmo_hit = tmo == TMO;
`else
  assign tmo_hit = 1'b0;
`endif
  // Frame FSM: header bytes are only special while hunting
  always_comb begin
    fst_n = fst;
    cnt_n = cnt;
    shreg_n = shreg;
    data_n = u.output_data;
    valid_n = 1'b0;
    err_n = 1'b0;
    busy_n = u.rxd_busy;
    case (fst)
      HUNT0: fst_n = (byte_stb && rx_byte == HDR_BYTE) ? HUNT1 : HUNT0;
      HUNT1: if (byte_stb || byte_ferr) begin
        fst_n = (byte_stb && rx_byte == HDR_BYTE) ? PAYLOAD : HUNT0;
        busy_n = byte_stb && rx_byte == HDR_BYTE;
        cnt_n = '0;
      end
      PAYLOAD: if (byte_stb) begin
        shreg_n = {shreg[W-9:0], rx_byte};
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          data_n = shreg_n;
          valid_n = 1'b1;
          busy_n = 1'b0;
          fst_n = HUNT0;
        end
      end else if (byte_ferr || tmo_hit) begin
        err_n = 1'b1;
        busy_n = 1'b0;
        fst_n = HUNT0;
      end
      default: fst_n = HUNT0;
    endcase
  end
  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) begin
      fst <= HUNT0;
      cnt <= '0;
      shreg <= '0;
      u.output_data <= '0;
      u.frame_valid <= 1'b0;
      u.frame_err <= 1'b0;
      u.rxd_busy <= 1'b0;
    end else begin
      fst <= fst_n;
      cnt <= cnt_n;
      shreg <= shreg_n;
      u.output_data <= data_n;
      u.frame_valid <= valid_n;
      u.frame_err <= err_n;
      u.rxd_busy <= busy_n;
    end
endmodule

// File: tb/tb_uart_frame_rx.sv
`timescale 1ns/1ps
// tb_uart_frame_rx: serialises byte streams onto fpga_rxd and checks frames against a byte-list framing model.
module tb_uart_frame_rx;
  localparam int N = 20;
  localparam logic [7:0] HDR = 8'h5A;
  localparam logic [159:0] T1 = 160'h0102030405060708090A0B0C0D0E0F1011121314;
  localparam logic [159:0] T2 = {20{8'hA5}};
  localparam logic [159:0] T3 = {8'h5A, {19{8'hA5}}};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] ph = 2'd0;
  always #10 clk = ~clk;
  always @(negedge clk) ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
  uart_frame_if #(.PAYLOAD_BYTES(N)) bus();
  assign bus.clken_16bps = (ph != 2'd0);
  uart_frame_rx dut(.clk_50m(clk), .rst_n(rst_n), .u(bus.slave));
  int checks = 0, failures = 0;
  int n_valid = 0, n_err = 0, n_both = 0;
  int v0, e0, exp_err;
  logic [159:0] got_q[$], exp_q[$];
  logic [7:0] sent_b[$];
  logic sent_ok[$];
  always @(negedge clk) if (rst_n) begin
    if (bus.frame_valid) begin
      n_valid <= n_valid + 1;
      got_q.push_back(bus.output_data);
    end
    if (bus.frame_err) n_err <= n_err + 1;
    if (bus.frame_valid && bus.frame_err) n_both <= n_both + 1;
  end
  initial begin
    #4000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!bus.clken_16bps) @(posedge clk);
    end
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic ok);
    bus.fpga_rxd = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      bus.fpga_rxd = b[i];
      ticks(16);
    end
    bus.fpga_rxd = ok;
    ticks(16);
    bus.fpga_rxd = 1'b1;
    sent_b.push_back(b);
    sent_ok.push_back(ok);
    ticks(ok ? int'($urandom_range(0, 3)) : 24);
  endtask
  task automatic send_hdr();
    send_byte(HDR, 1'b1);
    send_byte(HDR, 1'b1);
  endtask
  task automatic send_rand(input int n);
    repeat (n) send_byte(8'($urandom_range(0, 255)), 1'b1);
  endtask
  function automatic logic [7:0] rnd_nh();
    logic [7:0] b = 8'($urandom_range(0, 255));
    return (b == HDR) ? 8'h00 : b;
  endfunction
  function automatic logic [159:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : {160{1'bx}};
  endfunction
  // Framing model: find a good HDR HDR pair, take the next N good bytes; a bad stop byte aborts
  task automatic model();
    int i, k, taken;
    bit bad;
    logic [159:0] w;
    exp_q.delete();
    exp_err = 0;
    i = 0;
    while (i + 1 < sent_b.size()) begin
      if (sent_ok[i] && sent_ok[i+1] && sent_b[i] == HDR && sent_b[i+1] == HDR) begin
        w = '0;
        k = i + 2;
        taken = 0;
        bad = 0;
        while (k < sent_b.size() && taken < N && !bad) begin
          if (!sent_ok[k]) bad = 1;
          else begin
            w = {w[151:0], sent_b[k]};
            taken++;
          end
          k++;
        end
        if (bad) exp_err++;
        else if (taken == N) exp_q.push_back(w);
        i = k;
      end else i++;
    end
  endtask
  task automatic start_test();
    sent_b.delete();
    sent_ok.delete();
    got_q.delete();
    v0 = n_valid;
    e0 = n_err;
  endtask
  task automatic finish_test(input string tag);
    ticks(4);
    model();
    chk({tag, "_nvalid"}, 160'(n_valid - v0), 160'(exp_q.size()));
    chk({tag, "_nerr"}, 160'(n_err - e0), 160'(exp_err));
    foreach (exp_q[i]) chk($sformatf("%s_data%0d", tag, i), got_at(i), exp_q[i]);
  endtask
  initial begin
    bus.fpga_rxd = 1'b1;
    @(negedge clk);
    chk("rst_data", bus.output_data, '0);
    chk("rst_valid", 160'(bus.frame_valid), 0);
    chk("rst_err", 160'(bus.frame_err), 0);
    chk("rst_busy", 160'(bus.rxd_busy), 0);
    ticks(3);
    rst_n = 1'b1;
    ticks(4);
    start_test();
    send_hdr();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    chk("t1_busy_mid", 160'(bus.rxd_busy), 1);
    for (int i = 6; i <= 20; i++) send_byte(8'(i), 1'b1);
    finish_test("t1");
    chk("t1_const", got_at(0), T1);
    chk("t1_busy_end", 160'(bus.rxd_busy), 0);
    start_test();
    send_byte(8'h00, 1'b1);
    send_byte(HDR, 1'b1);
    send_byte(8'h33, 1'b1);
    send_hdr();
    repeat (20) send_byte(8'hA5, 1'b1);
    finish_test("t2");
    chk("t2_const", got_at(0), T2);
    start_test();
    send_hdr();
    send_byte(HDR, 1'b1);
    repeat (19) send_byte(8'hA5, 1'b1);
    finish_test("t3");
    chk("t3_const", got_at(0), T3);
    start_test();
    send_hdr();
    repeat (6) send_byte(rnd_nh(), 1'b1);
    send_byte(rnd_nh(), 1'b0);
    chk("t4_hold", bus.output_data, T3);
    chk("t4_busy", 160'(bus.rxd_busy), 0);
    send_hdr();
    send_rand(20);
    finish_test("t4");
    start_test();
    send_byte(HDR, 1'b1);
    bus.fpga_rxd = 1'b0;
    ticks(3);
    bus.fpga_rxd = 1'b1;
    ticks(20);
    chk("t5_glitch_busy", 160'(bus.rxd_busy), 0);
    send_byte(HDR, 1'b1);
    send_rand(20);
    finish_test("t5g");
    start_test();
    send_hdr();
    send_rand(10);
    chk("t5_busy_pre", 160'(bus.rxd_busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_data", bus.output_data, '0);
    chk("t5_rst_valid", 160'(bus.frame_valid), 0);
    chk("t5_rst_err", 160'(bus.frame_err), 0);
    chk("t5_rst_busy", 160'(bus.rxd_busy), 0);
    ticks(5);
    rst_n = 1'b1;
    ticks(2);
    start_test();
    send_hdr();
    send_rand(20);
    finish_test("t5r");
    start_test();
    send_hdr();
    repeat (10) send_byte(rnd_nh(), 1'b1);
    ticks(620);
    chk("t6_busy_wait", 160'(bus.rxd_busy), 1);
    chk("t6_err_early", 160'(n_err - e0), 0);
    ticks(80);
`ifdef UART_FRAME_TIMEOUT_EN
    chk("t6_err_tmo", 160'(n_err - e0), 1);
    chk("t6_busy_tmo", 160'(bus.rxd_busy), 0);
    repeat (10) send_byte(rnd_nh(), 1'b1);
    ticks(4);
    chk("t6_nvalid", 160'(n_valid - v0), 0);
    chk("t6_nerr", 160'(n_err - e0), 1);
`else
    chk("t6_err_none", 160'(n_err - e0), 0);
    chk("t6_busy_hold", 160'(bus.rxd_busy), 1);
    send_rand(10);
    finish_test("t6");
`endif
    start_test();
    repeat (4) send_byte(($urandom_range(0, 2) == 0) ? HDR : 8'($urandom_range(0, 255)), 1'b1);
    send_hdr();
    send_rand(20);
    finish_test("t7");
    chk("exclusive", 160'(n_both), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
